// File: rtl/turf_udp_frame_builder.sv
// TURF UDP frame builder: splits the event-wide payload stream into per-fragment AXI4-Stream
// frames, each a routing beat followed by ceil(len/8) payload beats, and counts fragments and errors.
//
// state | meaning
// IDLE  | waiting for a fragment header
// ROUTE | presenting the routing beat {dest_ip, dest_port, src_port}
// PAY   | passing payload beats through until the fragment length is used up
// DROP  | bad header: discarding payload up to the end of the event
`timescale 1ns/1ps

module turf_udp_frame_builder #(
    parameter logic [15:0] MAX_LEN = 16'd8192
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [63:0] s_hdr_tdata,
    input  logic [15:0] s_hdr_tuser,
    input  logic        s_hdr_tvalid,
    output logic        s_hdr_tready,
    input  logic [63:0] s_payload_tdata,
    input  logic [7:0]  s_payload_tkeep,
    input  logic        s_payload_tlast,
    input  logic        s_payload_tvalid,
    output logic        s_payload_tready,
    output logic [63:0] m_frame_tdata,
    output logic [7:0]  m_frame_tkeep,
    output logic        m_frame_tlast,
    output logic        m_frame_tvalid,
    input  logic        m_frame_tready,
    output logic [15:0] m_frame_len,
    output logic [31:0] frag_count_o,
    output logic [15:0] err_count_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUTE,
        S_PAY,
        S_DROP
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_active;
    logic [31:0] r_dest_ip;
    logic [15:0] r_dest_port;
    logic [15:0] r_src_port;
    logic [15:0] r_len;
    logic [12:0] r_cnt;
    logic [31:0] r_frag_count;
    logic [15:0] r_err_count;
    logic        r_err;

    logic        w_hdr_hs;
    logic [15:0] w_len_in;
    logic        w_len_bad;
    logic [16:0] w_len_p7;
    logic [12:0] w_beats;
    logic        w_cnt_last;
    logic [7:0]  w_keep_last;
    logic        w_frag_inc;
    logic        w_err_evt;
    logic        w_cnt_dec;

    // Payload byte enables are ignored; the header length is the only source of truth.
    logic        w_unused_keep;
    assign w_unused_keep = ^s_payload_tkeep;

    assign w_len_in   = s_hdr_tdata[15:0];
    assign w_len_bad  = (w_len_in == 16'd0) || (w_len_in > MAX_LEN);
    assign w_len_p7   = {1'b0, w_len_in} + 17'd7;
    assign w_beats    = w_len_p7[15:3];
    assign w_hdr_hs   = (r_state == S_IDLE) && r_active && s_hdr_tvalid;
    assign w_cnt_last = (r_cnt == 13'd1);

    always_comb begin
        w_keep_last = 8'hFF;
        if (r_len[2:0] != 3'd0) begin
            w_keep_last = (8'h01 << r_len[2:0]) - 8'h01;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        s_hdr_tready     = 1'b0;
        s_payload_tready = 1'b0;
        m_frame_tvalid   = 1'b0;
        m_frame_tdata    = {r_dest_ip, r_dest_port, r_src_port};
        m_frame_tkeep    = 8'hFF;
        m_frame_tlast    = 1'b0;
        w_frag_inc       = 1'b0;
        w_err_evt        = 1'b0;
        w_cnt_dec        = 1'b0;
        case (r_state)
            S_IDLE: begin
                s_hdr_tready = r_active;
                if (r_active && s_hdr_tvalid) begin
                    w_err_evt   = w_len_bad;
                    w_state_nxt = w_len_bad ? S_DROP : S_ROUTE;
                end
            end
            S_ROUTE: begin
                m_frame_tvalid = 1'b1;
                if (m_frame_tready) begin
                    w_state_nxt = S_PAY;
                end
            end
            S_PAY: begin
                m_frame_tvalid   = s_payload_tvalid;
                s_payload_tready = m_frame_tready;
                m_frame_tdata    = s_payload_tdata;
                if (w_cnt_last) begin
                    m_frame_tlast = 1'b1;
                    m_frame_tkeep = w_keep_last;
                end else if (s_payload_tlast) begin
                    m_frame_tlast = 1'b1;
                end
                if (s_payload_tvalid && m_frame_tready) begin
                    if (w_cnt_last || s_payload_tlast) begin
                        // Event ended before the header length was used up.
                        w_err_evt   = !w_cnt_last;
                        w_frag_inc  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_dec = 1'b1;
                    end
                end
            end
            S_DROP: begin
                s_payload_tready = 1'b1;
                if (s_payload_tvalid && s_payload_tlast) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_active     <= 1'b0;
            r_dest_ip    <= 32'd0;
            r_dest_port  <= 16'd0;
            r_src_port   <= 16'd0;
            r_len        <= 16'd0;
            r_cnt        <= 13'd0;
            r_frag_count <= 32'd0;
            r_err_count  <= 16'd0;
            r_err        <= 1'b0;
        end else begin
            r_active <= 1'b1;
            r_err    <= w_err_evt;
            if (w_hdr_hs) begin
                r_dest_ip   <= s_hdr_tdata[63:32];
                r_dest_port <= s_hdr_tdata[31:16];
                r_src_port  <= s_hdr_tuser;
                r_len       <= w_len_in;
                r_cnt       <= w_beats;
            end else if (w_cnt_dec) begin
                r_cnt <= r_cnt - 13'd1;
            end
            if (w_frag_inc) begin
                r_frag_count <= r_frag_count + 32'd1;
            end
            if (w_err_evt && (r_err_count != 16'hFFFF)) begin
                r_err_count <= r_err_count + 16'd1;
            end
        end
    end

    assign m_frame_len  = r_len;
    assign frag_count_o = r_frag_count;
    assign err_count_o  = r_err_count;
    assign err_o        = r_err;

endmodule

// File: tb/tb_turf_udp_frame_builder.sv
// Bench for turf_udp_frame_builder: stream-level reference model feeds a scoreboard queue,
// a negedge monitor pops and compares every output beat.
`timescale 1ns/1ps

module tb_turf_udp_frame_builder;

    logic        aclk = 1'b0;
    logic        areset;
    logic [63:0] s_hdr_tdata;
    logic [15:0] s_hdr_tuser;
    logic        s_hdr_tvalid;
    logic        s_hdr_tready;
    logic [63:0] s_payload_tdata;
    logic [7:0]  s_payload_tkeep;
    logic        s_payload_tlast;
    logic        s_payload_tvalid;
    logic        s_payload_tready;
    logic [63:0] m_frame_tdata;
    logic [7:0]  m_frame_tkeep;
    logic        m_frame_tlast;
    logic        m_frame_tvalid;
    logic        m_frame_tready;
    logic [15:0] m_frame_len;
    logic [31:0] frag_count_o;
    logic [15:0] err_count_o;
    logic        err_o;

    always #5 aclk = ~aclk;

    turf_udp_frame_builder #(.MAX_LEN(16'd8192)) dut (
        .aclk             (aclk),
        .areset           (areset),
        .s_hdr_tdata      (s_hdr_tdata),
        .s_hdr_tuser      (s_hdr_tuser),
        .s_hdr_tvalid     (s_hdr_tvalid),
        .s_hdr_tready     (s_hdr_tready),
        .s_payload_tdata  (s_payload_tdata),
        .s_payload_tkeep  (s_payload_tkeep),
        .s_payload_tlast  (s_payload_tlast),
        .s_payload_tvalid (s_payload_tvalid),
        .s_payload_tready (s_payload_tready),
        .m_frame_tdata    (m_frame_tdata),
        .m_frame_tkeep    (m_frame_tkeep),
        .m_frame_tlast    (m_frame_tlast),
        .m_frame_tvalid   (m_frame_tvalid),
        .m_frame_tready   (m_frame_tready),
        .m_frame_len      (m_frame_len),
        .frag_count_o     (frag_count_o),
        .err_count_o      (err_count_o),
        .err_o            (err_o)
    );

    typedef struct packed {
        logic [63:0] data;
        logic [15:0] user;
    } hdr_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } pay_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [15:0] len;
    } exp_t;

    hdr_t hdr_q[$];
    hdr_t m_hq[$];
    pay_t pay_q[$];
    pay_t m_pq[$];
    exp_t exp_q[$];

    int checks     = 0;
    int errors     = 0;
    int beats_seen = 0;
    int err_pulses = 0;
    int m_frag     = 0;
    int m_err      = 0;
    bit rnd_ready  = 1'b0;

    // Downstream ready: either always ready or randomly stalling.
    initial begin : ready_drv
        m_frame_tready = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            m_frame_tready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    initial begin : hdr_drv
        hdr_t h;
        s_hdr_tvalid = 1'b0;
        s_hdr_tdata  = 64'd0;
        s_hdr_tuser  = 16'd0;
        forever begin
            @(posedge aclk);
            #1;
            if (!areset && hdr_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                h            = hdr_q[0];
                s_hdr_tdata  = h.data;
                s_hdr_tuser  = h.user;
                s_hdr_tvalid = 1'b1;
                do @(negedge aclk); while (!s_hdr_tready && !areset);
                @(posedge aclk);
                #1;
                if (!areset && hdr_q.size() > 0) void'(hdr_q.pop_front());
                s_hdr_tvalid = 1'b0;
            end
        end
    end

    initial begin : pay_drv
        pay_t p;
        s_payload_tvalid = 1'b0;
        s_payload_tdata  = 64'd0;
        s_payload_tkeep  = 8'd0;
        s_payload_tlast  = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            if (!areset && pay_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                p                = pay_q[0];
                s_payload_tdata  = p.data;
                s_payload_tkeep  = p.keep;
                s_payload_tlast  = p.last;
                s_payload_tvalid = 1'b1;
                do @(negedge aclk); while (!s_payload_tready && !areset);
                @(posedge aclk);
                #1;
                if (!areset && pay_q.size() > 0) void'(pay_q.pop_front());
                s_payload_tvalid = 1'b0;
            end
        end
    end

    initial begin : mon
        exp_t        e;
        logic        stall;
        logic [72:0] prev;
        stall = 1'b0;
        prev  = '0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                stall      = 1'b0;
                err_pulses = 0;
            end else begin
                if (stall) begin
                    checks++;
                    if (!m_frame_tvalid || {m_frame_tdata, m_frame_tkeep, m_frame_tlast} !== prev) begin
                        errors++;
                        $display("FAIL hold_stable: got valid=%0b beat=%h required valid=1 beat=%h",
                                 m_frame_tvalid, {m_frame_tdata, m_frame_tkeep, m_frame_tlast}, prev);
                    end
                end
                if (m_frame_tvalid && m_frame_tready) begin
                    beats_seen++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat: got data=%h last=%0b required no beat",
                                 m_frame_tdata, m_frame_tlast);
                    end else begin
                        e = exp_q.pop_front();
                        if (m_frame_tdata !== e.data || m_frame_tkeep !== e.keep ||
                            m_frame_tlast !== e.last || m_frame_len !== e.len) begin
                            errors++;
                            $display("FAIL frame_beat: got data=%h keep=%h last=%0b len=%0d required data=%h keep=%h last=%0b len=%0d",
                                     m_frame_tdata, m_frame_tkeep, m_frame_tlast, m_frame_len,
                                     e.data, e.keep, e.last, e.len);
                        end
                    end
                end
                stall = m_frame_tvalid && !m_frame_tready;
                prev  = {m_frame_tdata, m_frame_tkeep, m_frame_tlast};
                if (err_o) err_pulses++;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    task automatic add_hdr(input logic [31:0] ip, input logic [15:0] port,
                           input logic [15:0] src, input logic [15:0] len);
        hdr_t h;
        h.data = {ip, port, len};
        h.user = src;
        hdr_q.push_back(h);
        m_hq.push_back(h);
    endtask

    task automatic add_pay(input int n);
        pay_t p;
        for (int i = 0; i < n; i++) begin
            p.data = {$urandom, $urandom};
            p.keep = 8'($urandom);
            p.last = (i == n - 1);
            pay_q.push_back(p);
            m_pq.push_back(p);
        end
    endtask

    // Stream-level model: each header claims ceil(len/8) words of the event stream,
    // cut short by an event end; bad headers swallow the rest of the event.
    task automatic model_run();
        hdr_t h;
        pay_t p;
        exp_t e;
        int   len;
        int   nb;
        int   r;
        while (m_hq.size() > 0) begin
            h   = m_hq.pop_front();
            len = int'(h.data[15:0]);
            if (len == 0 || len > 8192) begin
                m_err++;
                do begin
                    if (m_pq.size() == 0) break;
                    p = m_pq.pop_front();
                end while (!p.last);
            end else begin
                nb     = (len + 7) / 8;
                e.data = {h.data[63:16], h.user};
                e.keep = 8'hFF;
                e.last = 1'b0;
                e.len  = h.data[15:0];
                exp_q.push_back(e);
                for (int i = 0; i < nb; i++) begin
                    if (m_pq.size() == 0) break;
                    p      = m_pq.pop_front();
                    e.data = p.data;
                    if (i == nb - 1) begin
                        r      = len - 8 * (nb - 1);
                        e.keep = 8'hFF >> (8 - r);
                        e.last = 1'b1;
                        exp_q.push_back(e);
                        m_frag++;
                        break;
                    end else if (p.last) begin
                        e.keep = 8'hFF;
                        e.last = 1'b1;
                        exp_q.push_back(e);
                        m_frag++;
                        m_err++;
                        break;
                    end else begin
                        e.keep = 8'hFF;
                        e.last = 1'b0;
                        exp_q.push_back(e);
                    end
                end
            end
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((hdr_q.size() != 0 || pay_q.size() != 0 || exp_q.size() != 0) && n < 30000) begin
            @(posedge aclk);
            n++;
        end
        repeat (4) @(posedge aclk);
        #1;
        checks++;
        if (n >= 30000) begin
            errors++;
            $display("FAIL %s_timeout: got pending hdr=%0d pay=%0d exp=%0d required 0",
                     name, hdr_q.size(), pay_q.size(), exp_q.size());
        end
    endtask

    task automatic check_counts(input string name);
        chk({name, "_frag_count"}, 64'(frag_count_o), 64'(m_frag));
        chk({name, "_err_count"}, 64'(err_count_o), 64'(m_err));
        chk({name, "_err_pulses"}, 64'(err_pulses), 64'(m_err));
    endtask

    task automatic check_reset(input string name);
        chk({name, "_tvalid"}, 64'(m_frame_tvalid), 64'd0);
        chk({name, "_hdr_tready"}, 64'(s_hdr_tready), 64'd0);
        chk({name, "_pay_tready"}, 64'(s_payload_tready), 64'd0);
        chk({name, "_err_o"}, 64'(err_o), 64'd0);
        chk({name, "_frag_count"}, 64'(frag_count_o), 64'd0);
        chk({name, "_err_count"}, 64'(err_count_o), 64'd0);
        chk({name, "_frame_len"}, 64'(m_frame_len), 64'd0);
    endtask

    initial begin : main
        int mode;
        int k;
        int tot;
        int l;
        int n;
        int base;
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        #2;
        check_reset("init");
        areset = 1'b0;

        add_hdr(32'hC0A80001, 16'd5000, 16'h5430, 16'd24);
        add_pay(3);
        model_run();
        wait_drain("t1");
        check_counts("t1");
        chk("t1_frame_len", 64'(m_frame_len), 64'd24);

        add_hdr(32'h0A000002, 16'd6000, 16'h1111, 16'd20);
        add_pay(3);
        model_run();
        wait_drain("t2");
        check_counts("t2");

        add_hdr(32'h0A000003, 16'd7000, 16'h2222, 16'd72);
        add_hdr(32'h0A000004, 16'd7001, 16'h2223, 16'd16);
        add_pay(11);
        model_run();
        wait_drain("t3");
        check_counts("t3");

        add_hdr(32'h0A000005, 16'd7002, 16'h3333, 16'd40);
        add_pay(2);
        add_hdr(32'h0A000006, 16'd7003, 16'h3334, 16'd8);
        add_pay(1);
        model_run();
        wait_drain("t4");
        check_counts("t4");

        add_hdr(32'h0A000007, 16'd7004, 16'h4444, 16'd0);
        add_pay(4);
        add_hdr(32'h0A000008, 16'd7005, 16'h4445, 16'd8193);
        add_pay(2);
        add_hdr(32'h0A000009, 16'd7006, 16'h4446, 16'd8192);
        add_pay(1024);
        model_run();
        wait_drain("t5");
        check_counts("t5");

        rnd_ready = 1'b1;
        add_hdr(32'h0A00000A, 16'd7007, 16'h5555, 16'd72);
        add_hdr(32'h0A00000B, 16'd7008, 16'h5556, 16'd16);
        add_pay(11);
        model_run();
        for (int ev = 0; ev < 40; ev++) begin
            mode = int'($urandom_range(0, 9));
            if (mode <= 5) begin
                k   = int'($urandom_range(1, 3));
                tot = 0;
                for (int j = 0; j < k; j++) begin
                    l = int'($urandom_range(1, 200));
                    add_hdr($urandom, 16'($urandom), 16'($urandom), 16'(l));
                    tot += (l + 7) / 8;
                end
                add_pay(tot);
            end else if (mode <= 7) begin
                l = int'($urandom_range(17, 200));
                add_hdr($urandom, 16'($urandom), 16'($urandom), 16'(l));
                add_pay(int'($urandom_range(1, (l + 7) / 8 - 1)));
            end else begin
                l = (mode == 8) ? 0 : 8193 + int'($urandom_range(0, 57000));
                add_hdr($urandom, 16'($urandom), 16'($urandom), 16'(l));
                add_pay(int'($urandom_range(1, 4)));
            end
            model_run();
        end
        wait_drain("t6_random");
        check_counts("t6_random");

        rnd_ready = 1'b0;
        base = beats_seen;
        add_hdr(32'h0A00000C, 16'd7009, 16'h6666, 16'd72);
        add_pay(9);
        model_run();
        n = 0;
        while (beats_seen < base + 4 && n < 2000) begin
            @(posedge aclk);
            n++;
        end
        chk("t6_reach_pay", 64'(beats_seen >= base + 4), 64'd1);
        @(posedge aclk);
        #2;
        areset = 1'b1;
        hdr_q.delete();
        pay_q.delete();
        m_hq.delete();
        m_pq.delete();
        repeat (2) @(posedge aclk);
        #2;
        exp_q.delete();
        m_frag = 0;
        m_err  = 0;
        check_reset("t6_midpay");
        areset = 1'b0;

        add_hdr(32'hC0A80001, 16'd5000, 16'h5430, 16'd24);
        add_pay(3);
        model_run();
        wait_drain("t6_after_reset");
        check_counts("t6_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
